control_pipeline: RTL
=====================

# control_pipeline

Carries the decoder's control word from Decode through Execute, Memory and Writeback for the pipelined ARM core. It also owns the architectural NZCV flags register and evaluates the 4-bit condition field in Execute. It gates register, memory, PC and branch writes for instructions whose condition fails. It sits directly downstream of the pipeline decoder and feeds the datapath muxes, data memory write enable, register file write enable and the hazard unit.

## Interface
- No parameters; all widths fixed.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- PCSD, RegWD, MemWD, NoWriteD, MemtoRegD, ALUSrcD, BranchD  in  1 each  Decode-stage control from the decoder.
- FlagWD  in  2  [1] = update N,Z; [0] = update C,V.
- ALUControlD  in  4  ALU operation code.
- CondD  in  4  instruction bits [31:28].
- ALUFlagsE  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlushE  in  1  from hazard unit; clears the Execute control register.
- ALUSrcE  out  1  registered; ALU B-source select.
- ALUControlE  out  4  registered ALU operation.
- MemtoRegE  out  1  registered; used by the hazard unit for load-use detection.
- RegWriteE  out  1  gated write enable in Execute, for forwarding and hazard logic.
- BranchTakenE  out  1  combinational; BranchE & CondExE.
- MemWriteM  out  1  data memory write enable.
- RegWriteM, MemtoRegM  out  1 each  Memory-stage control.
- RegWriteW, MemtoRegW, PCSrcW  out  1 each  Writeback-stage control.
- PCWrPending  out  1  PCSD | PCSrcE | PCSrcM.
- FlagsOut  out  4  current registered {N,Z,C,V}.

## Operation
- E register: captures all D-stage inputs each cycle.
  - If FlushE=1, it loads all zeros instead (bubble).
  - ALUControlE=0000 after a flush.
- CondExE is combinational from CondE and the registered Flags:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: treated as 1.
- Gated Execute signals:
  - PCSrcE = PCSE & CondExE.
  - RegWriteE = RegWE & CondExE & !NoWriteE.
  - MemWriteE = MemWE & CondExE.
  - BranchTakenE = BranchE & CondExE.
- Flags register:
  - When FlagWE[1] & CondExE, N,Z load from ALUFlagsE[3:2].
  - When FlagWE[0] & CondExE, C,V load from ALUFlagsE[1:0].
  - The two halves update independently; otherwise they hold.
- M register: captures PCSrcE, RegWriteE, MemWriteE, MemtoRegE each cycle. It has no stall or flush.
- W register: captures PCSrcM, RegWriteM, MemtoRegM each cycle.
- A squashed instruction (CondExE=0) proceeds as a bubble: all write enables are 0 in M and W.

## Timing
- Reset (rst_n=0, asynchronous): all E/M/W registers and Flags clear to 0 immediately. All outputs are then 0, except that the combinational gated outputs evaluate from the zeroed E register. This gives CondE=0000 with Z=0, so CondExE=0 and all gated outputs are 0.
- Reset mid-operation discards in-flight instructions; no write enable pulses after rst_n falls.
- Latency: a D-stage control appears in E 1 cycle later, in M 2 cycles later and in W 3 cycles later.
- Flags written by an instruction in E are visible to the very next instruction in E (one cycle later). Back-to-back CMP→BEQ therefore needs no stall.
- A failed-condition instruction never writes Flags, even if FlagWE≠0.
- FlushE and a valid D input in the same cycle: the flush wins, and E holds a bubble.
- BranchTakenE is valid in the same cycle the branch occupies E.

## Test plan
- Reset: drive random D inputs, hold rst_n=0 → all outputs 0 and FlagsOut=0000. Release rst_n → first D word appears on E outputs after one edge.
- CMP then BEQ:
  - Stimulus: SUB-type with FlagWD=11, NoWriteD=1, then BranchD=1, CondD=0000. ALUFlagsE=0100 in the CMP's E cycle.
  - Required: FlagsOut=0100 the next cycle, BranchTakenE=1, RegWriteE=0 for the CMP.
- Condition fail:
  - Stimulus: Flags=0000, ADDEQ with RegWD=1, FlagWD=11, ALUFlagsE=1001.
  - Required: RegWriteE=0, Flags stay 0000, RegWriteM=0 and RegWriteW=0 in the following cycles.
- Partial flag write: Flags=1111, FlagWD=10, ALUFlagsE=0000, AL → Flags=0011.
- Flush: STR (MemWD=1) in D with FlushE=1 → ALUControlE=0000, MemWriteM=0 next-next cycle.
- PC pipeline:
  - Stimulus: an AL instruction with PCSD=1, RegWD=1.
  - Required: PCWrPending=1 for three consecutive cycles (D, E, M), then PCSrcW=1 on the fourth.

Source files
------------

// File: rtl/control_pipeline.sv
// Control-word pipeline (Decode -> Execute -> Memory -> Writeback) for the ARM core.
// Owns the NZCV flags and squashes writes of instructions whose condition fails.
module control_pipeline (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PCSD,
    input  logic       RegWD,
    input  logic       MemWD,
    input  logic       NoWriteD,
    input  logic       MemtoRegD,
    input  logic       ALUSrcD,
    input  logic       BranchD,
    input  logic [1:0] FlagWD,
    input  logic [3:0] ALUControlD,
    input  logic [3:0] CondD,
    input  logic [3:0] ALUFlagsE,
    input  logic       FlushE,
    output logic       ALUSrcE,
    output logic [3:0] ALUControlE,
    output logic       MemtoRegE,
    output logic       RegWriteE,
    output logic       BranchTakenE,
    output logic       MemWriteM,
    output logic       RegWriteM,
    output logic       MemtoRegM,
    output logic       RegWriteW,
    output logic       MemtoRegW,
    output logic       PCSrcW,
    output logic       PCWrPending,
    output logic [3:0] FlagsOut
);

    logic       pcs_e;
    logic       reg_w_e;
    logic       mem_w_e;
    logic       no_write_e;
    logic       branch_e;
    logic [1:0] flag_w_e;
    logic [3:0] cond_e;
    logic [3:0] flags;
    logic       cond_ex;
    logic       pcsrc_e;
    logic       mem_write_e;
    logic       pcsrc_m;

    // Execute register; a flush loads an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcs_e       <= 1'b0;
            reg_w_e     <= 1'b0;
            mem_w_e     <= 1'b0;
            no_write_e  <= 1'b0;
            MemtoRegE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            branch_e    <= 1'b0;
            flag_w_e    <= 2'b00;
            ALUControlE <= 4'b0000;
            cond_e      <= 4'b0000;
        end else if (FlushE) begin
            pcs_e       <= 1'b0;
            reg_w_e     <= 1'b0;
            mem_w_e     <= 1'b0;
            no_write_e  <= 1'b0;
            MemtoRegE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            branch_e    <= 1'b0;
            flag_w_e    <= 2'b00;
            ALUControlE <= 4'b0000;
            cond_e      <= 4'b0000;
        end else begin
            pcs_e       <= PCSD;
            reg_w_e     <= RegWD;
            mem_w_e     <= MemWD;
            no_write_e  <= NoWriteD;
            MemtoRegE   <= MemtoRegD;
            ALUSrcE     <= ALUSrcD;
            branch_e    <= BranchD;
            flag_w_e    <= FlagWD;
            ALUControlE <= ALUControlD;
            cond_e      <= CondD;
        end
    end

    // flags = {N, Z, C, V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = !flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = !flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = !flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = !flags[0];
            4'b1000: cond_ex = flags[1] & !flags[2];
            4'b1001: cond_ex = !flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = !flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    assign pcsrc_e      = pcs_e & cond_ex;
    assign RegWriteE    = reg_w_e & cond_ex & !no_write_e;
    assign mem_write_e  = mem_w_e & cond_ex;
    assign BranchTakenE = branch_e & cond_ex;

    // N,Z and C,V halves update independently, only for passing instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w_e[1] && cond_ex) flags[3:2] <= ALUFlagsE[3:2];
            if (flag_w_e[0] && cond_ex) flags[1:0] <= ALUFlagsE[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcsrc_m   <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            pcsrc_m   <= pcsrc_e;
            RegWriteM <= RegWriteE;
            MemWriteM <= mem_write_e;
            MemtoRegM <= MemtoRegE;
            PCSrcW    <= pcsrc_m;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
        end
    end

    // The Decode term is masked during reset so every output reads 0 while rst_n is low.
    assign PCWrPending = (PCSD & rst_n) | pcsrc_e | pcsrc_m;
    assign FlagsOut    = flags;

endmodule
